// File: rtl/irq_priority_encoder_pkg.sv
// Shared constants and FSM state type for the interrupt priority encoder.
package irq_pkg;

    localparam int IRQ_N_REQ  = 8;
    localparam int IRQ_CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } irq_state_t;

    // One-hot of a request index; used to clear the acknowledged pending bit.
    function automatic logic [IRQ_N_REQ-1:0] irq_onehot(input logic [IRQ_CODE_W-1:0] code);
        logic [IRQ_N_REQ-1:0] one;
        one = {{(IRQ_N_REQ-1){1'b0}}, 1'b1};
        return one << code;
    endfunction

endpackage

// File: rtl/irq_priority_encoder_prio_enc8to3.sv
// Combinational 8-to-3 priority encoder: highest set index wins.
module prio_enc8to3
    import irq_pkg::*;
(
    input  logic [IRQ_N_REQ-1:0]  eligible,
    output logic [IRQ_CODE_W-1:0] code,
    output logic                  any
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        code = '0;
        any  = |eligible;
        for (int i = 0; i < IRQ_N_REQ; i++) begin
            if (eligible[i]) begin
                code = i[IRQ_CODE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/irq_priority_encoder.sv
// Registered interrupt priority encoder with sticky pending bits and a
// valid/ack handshake towards the CPU trap logic.
// Optional build macro IRQ_MASK_EN adds the irq_mask port, which gates
// eligibility only (masked rises are still latched into pending).
//
// state | meaning
// IDLE  | no code presented; pick highest eligible pending line
// BUSY  | code presented and held stable until irq_ack
module irq_priority_encoder
    import irq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IRQ_N_REQ-1:0]  req_in,
`ifdef IRQ_MASK_EN
    input  logic [IRQ_N_REQ-1:0]  irq_mask,
`endif
    input  logic                  irq_ack,
    output logic                  irq_valid,
    output logic [IRQ_CODE_W-1:0] irq_code,
    output logic [IRQ_N_REQ-1:0]  pending
);

    irq_state_t             state, state_nxt;
    logic [IRQ_N_REQ-1:0]   req_q;
    logic [IRQ_N_REQ-1:0]   rise;
    logic [IRQ_N_REQ-1:0]   clr;
    logic [IRQ_N_REQ-1:0]   pending_nxt;
    logic [IRQ_N_REQ-1:0]   eligible;
    logic [IRQ_CODE_W-1:0]  enc_code;
    logic                   enc_any;
    logic                   valid_nxt;
    logic [IRQ_CODE_W-1:0]  code_nxt;

`ifdef IRQ_MASK_EN
    assign eligible = pending & irq_mask;
`else
    assign eligible = pending;
`endif

    prio_enc8to3 u_prio_enc (
        .eligible (eligible),
        .code     (enc_code),
        .any      (enc_any)
    );

    // Edge detect and pending update; a rise in the ack cycle beats the clear.
    always_comb begin
        rise        = req_in & ~req_q;
        clr         = '0;
        if (state == BUSY && irq_ack) begin
            clr = irq_onehot(irq_code);
        end
        pending_nxt = (pending & ~clr) | rise;
    end

    // Next-state and output-register logic for the presentation handshake.
    always_comb begin
        state_nxt = state;
        valid_nxt = irq_valid;
        code_nxt  = irq_code;
        case (state)
            IDLE: begin
                if (enc_any) begin
                    code_nxt  = enc_code;
                    valid_nxt = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (irq_ack) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // State, edge history, pending and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_q     <= '0;
            pending   <= '0;
            irq_valid <= 1'b0;
            irq_code  <= '0;
        end else begin
            state     <= state_nxt;
            req_q     <= req_in;
            pending   <= pending_nxt;
            irq_valid <= valid_nxt;
            irq_code  <= code_nxt;
        end
    end

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Self-checking bench for irq_priority_encoder; mask scenario runs when
// IRQ_MASK_EN is defined.
module tb_irq_priority_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_in;
`ifdef IRQ_MASK_EN
    logic [7:0] irq_mask;
`endif
    logic       irq_ack;
    logic       irq_valid;
    logic [2:0] irq_code;
    logic [7:0] pending;

    int errors = 0;
    int checks = 0;
    int sb[$];

    irq_priority_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
`ifdef IRQ_MASK_EN
        .irq_mask  (irq_mask),
`endif
        .irq_ack   (irq_ack),
        .irq_valid (irq_valid),
        .irq_code  (irq_code),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pops the expected code, waits (bounded) for presentation, acks, checks gap.
    task automatic present_and_ack(input string name);
        int exp;
        bit seen;
        seen = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s sb_empty: no expected code queued", name);
            return;
        end
        exp = sb.pop_front();
        for (int i = 0; i < 20 && !seen; i++) begin
            if (irq_valid === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: irq_valid never rose, expected code %0d", name, exp);
            return;
        end
        checks++;
        if (irq_code !== exp[2:0]) begin
            errors++;
            $display("FAIL %s code: got %0d expected %0d", name, irq_code, exp);
        end
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        checks++;
        if (irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s gap: irq_valid got %b expected 0", name, irq_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_in = 8'h00;
        irq_ack = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (irq_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", irq_valid);
        end
        checks++;
        if (pending !== 8'h00) begin
            errors++; $display("FAIL reset_pending: got %h expected 00", pending);
        end
        checks++;
        if (irq_code !== 3'd0) begin
            errors++; $display("FAIL reset_code: got %0d expected 0", irq_code);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        req_in = 8'h04;
        @(negedge clk);
        checks++;
        if (pending !== 8'h04 || irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_lat1: pending %h valid %b expected 04 0", pending, irq_valid);
        end
        @(negedge clk);
        checks++;
        if (irq_valid !== 1'b1 || irq_code !== 3'd2) begin
            errors++;
            $display("FAIL single_lat2: valid %b code %0d expected 1 2", irq_valid, irq_code);
        end
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        checks++;
        if (pending !== 8'h00 || irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: pending %h valid %b expected 00 0", pending, irq_valid);
        end
        req_in = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        req_in = 8'h91;
        @(negedge clk);
        req_in = 8'h00;
        sb.push_back(7);
        sb.push_back(4);
        sb.push_back(0);
        repeat (3) present_and_ack("simul");
        @(negedge clk);
        checks++;
        if (pending !== 8'h00 || irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain: pending %h valid %b expected 00 0", pending, irq_valid);
        end
    endtask

    task automatic test_no_preempt();
        req_in = 8'h08;
        repeat (2) @(negedge clk);
        req_in = 8'h48;
        repeat (3) @(negedge clk);
        checks++;
        if (irq_valid !== 1'b1 || irq_code !== 3'd3 || pending !== 8'h48) begin
            errors++;
            $display("FAIL no_preempt_hold: valid %b code %0d pending %h expected 1 3 48",
                     irq_valid, irq_code, pending);
        end
        sb.push_back(3);
        sb.push_back(6);
        present_and_ack("no_preempt");
        present_and_ack("no_preempt");
        req_in = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_set_wins();
        req_in = 8'h08;
        repeat (2) @(negedge clk);
        req_in = 8'h00;
        @(negedge clk);
        irq_ack = 1'b1;
        req_in  = 8'h08;
        @(negedge clk);
        irq_ack = 1'b0;
        checks++;
        if (irq_valid !== 1'b0 || pending !== 8'h08) begin
            errors++;
            $display("FAIL set_wins: valid %b pending %h expected 0 08", irq_valid, pending);
        end
        sb.push_back(3);
        present_and_ack("set_wins");
        req_in = 8'h00;
        @(negedge clk);
        checks++;
        if (pending !== 8'h00) begin
            errors++; $display("FAIL set_wins_drain: pending %h expected 00", pending);
        end
    endtask

    task automatic test_reset_mid();
        req_in = 8'h20;
        repeat (2) @(negedge clk);
        req_in = 8'hA0;
        @(negedge clk);
        checks++;
        if (irq_valid !== 1'b1 || irq_code !== 3'd5 || pending !== 8'hA0) begin
            errors++;
            $display("FAIL rst_mid_pre: valid %b code %0d pending %h expected 1 5 a0",
                     irq_valid, irq_code, pending);
        end
        rst = 1'b1;
        req_in = 8'h20;
        @(negedge clk);
        checks++;
        if (irq_valid !== 1'b0 || irq_code !== 3'd0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_clear: valid %b code %0d pending %h expected 0 0 00",
                     irq_valid, irq_code, pending);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(5);
        present_and_ack("rst_mid");
        repeat (3) @(negedge clk);
        checks++;
        if (irq_valid !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_once: valid %b pending %h expected 0 00", irq_valid, pending);
        end
        req_in = 8'h00;
        @(negedge clk);
    endtask

`ifdef IRQ_MASK_EN
    task automatic test_mask();
        irq_mask = 8'h0F;
        req_in   = 8'h80;
        @(negedge clk);
        req_in = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (pending !== 8'h80 || irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL mask_gate: pending %h valid %b expected 80 0", pending, irq_valid);
        end
        irq_mask = 8'hFF;
        sb.push_back(7);
        present_and_ack("mask");
        checks++;
        if (pending !== 8'h00) begin
            errors++; $display("FAIL mask_drain: pending %h expected 00", pending);
        end
    endtask
`endif

    initial begin
`ifdef IRQ_MASK_EN
        irq_mask = 8'hFF;
`endif
        rst = 1'b1;
        req_in = 8'h00;
        irq_ack = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_no_preempt();
        test_set_wins();
        test_reset_mid();
`ifdef IRQ_MASK_EN
        test_mask();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected codes never presented", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
